// File: rtl/topk_tracker.sv
// Streaming running top-K tracker: holds the K largest samples in a descending register array.
// Optional evicted-value outputs (evict_valid/evict_data) when TOPK_EVICT_OUT_EN is defined.
module topk_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int UNIQUE     = 1,
  parameter int IDX_W      = $clog2(K) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [IDX_W-1:0]      occ,
  output logic                  drop
`ifdef TOPK_EVICT_OUT_EN
  ,
  output logic                  evict_valid,
  output logic [DATA_WIDTH-1:0] evict_data
`endif
);

  logic [DATA_WIDTH-1:0] r_slot [K];
  logic [IDX_W-1:0]      r_occ;
  logic                  r_drop;

  logic [K-1:0]          w_gt;
  logic [K-1:0]          w_eq;
  logic [DATA_WIDTH-1:0] w_slot_next [K];
  logic [IDX_W-1:0]      w_p;
  logic                  w_dup;
  logic                  w_full;
  logic                  w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_cmp
      logic w_occupied;
      assign w_occupied = (IDX_W'(gi) < r_occ);
      assign w_eq[gi]   = w_occupied && (r_slot[gi] == din);
      if (UNIQUE != 0) begin : g_strict
        assign w_gt[gi] = w_occupied && (r_slot[gi] > din);
      end else begin : g_loose
        // Equal values rank above the newcomer so it lands below existing equals.
        assign w_gt[gi] = w_occupied && (r_slot[gi] >= din);
      end
    end
  endgenerate

  // Slots are sorted, so the compare mask is a prefix and its popcount is the insert position.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < K; i++) begin
      w_p = w_p + IDX_W'(w_gt[i]);
    end
  end

  assign w_dup    = (UNIQUE != 0) && (|w_eq);
  assign w_full   = (w_p == IDX_W'(K));
  assign w_accept = din_valid && !w_dup && !w_full;

  generate
    for (gi = 0; gi < K; gi++) begin : g_next
      if (gi == 0) begin : g_top
        assign w_slot_next[gi] = (w_p == '0) ? din : r_slot[gi];
      end else begin : g_rest
        assign w_slot_next[gi] = (w_p > IDX_W'(gi))  ? r_slot[gi] :
                                 (w_p == IDX_W'(gi)) ? din        : r_slot[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) r_slot[i] <= '0;
      r_occ  <= '0;
      r_drop <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < K; i++) r_slot[i] <= '0;
      r_occ  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= din_valid && !w_accept;
      if (w_accept) begin
        for (int i = 0; i < K; i++) r_slot[i] <= w_slot_next[i];
        if (r_occ != IDX_W'(K)) r_occ <= r_occ + IDX_W'(1);
      end
    end
  end

`ifdef TOPK_EVICT_OUT_EN
  logic                  r_evict_valid;
  logic [DATA_WIDTH-1:0] r_evict_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evict_valid <= 1'b0;
      r_evict_data  <= '0;
    end else if (clear) begin
      r_evict_valid <= 1'b0;
      r_evict_data  <= '0;
    end else begin
      r_evict_valid <= w_accept && (r_occ == IDX_W'(K));
      if (w_accept && (r_occ == IDX_W'(K))) r_evict_data <= r_slot[K-1];
    end
  end

  assign evict_valid = r_evict_valid;
  assign evict_data  = r_evict_data;
`endif

  // Mux by equality so out-of-range rd_idx never indexes the array.
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    for (int i = 0; i < K; i++) begin
      if ((rd_idx == IDX_W'(i)) && (IDX_W'(i) < r_occ)) begin
        dout       = r_slot[i];
        dout_valid = 1'b1;
      end
    end
  end

  assign occ  = r_occ;
  assign drop = r_drop;

endmodule

// File: tb/tb_topk_tracker.sv
// Directed bench for topk_tracker: a UNIQUE=1 and a UNIQUE=0 instance, K=4, 8-bit data.
module tb_topk_tracker;

  localparam int DW    = 8;
  localparam int K     = 4;
  localparam int IDX_W = $clog2(K) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear_u, din_valid_u;
  logic [DW-1:0]    din_u;
  logic [IDX_W-1:0] rd_idx_u;
  logic [DW-1:0]    dout_u;
  logic             dout_valid_u, drop_u;
  logic [IDX_W-1:0] occ_u;

  logic             clear_d, din_valid_d;
  logic [DW-1:0]    din_d;
  logic [IDX_W-1:0] rd_idx_d;
  logic [DW-1:0]    dout_d;
  logic             dout_valid_d, drop_d;
  logic [IDX_W-1:0] occ_d;

`ifdef TOPK_EVICT_OUT_EN
  logic             evict_valid_u, evict_valid_d;
  logic [DW-1:0]    evict_data_u, evict_data_d;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  topk_tracker #(.DATA_WIDTH(DW), .K(K), .UNIQUE(1), .IDX_W(IDX_W)) u_dut (
    .clk(clk), .reset(reset), .clear(clear_u), .din_valid(din_valid_u), .din(din_u),
    .rd_idx(rd_idx_u), .dout(dout_u), .dout_valid(dout_valid_u), .occ(occ_u), .drop(drop_u)
`ifdef TOPK_EVICT_OUT_EN
    , .evict_valid(evict_valid_u), .evict_data(evict_data_u)
`endif
  );

  topk_tracker #(.DATA_WIDTH(DW), .K(K), .UNIQUE(0), .IDX_W(IDX_W)) u_dut_dup (
    .clk(clk), .reset(reset), .clear(clear_d), .din_valid(din_valid_d), .din(din_d),
    .rd_idx(rd_idx_d), .dout(dout_d), .dout_valid(dout_valid_d), .occ(occ_d), .drop(drop_d)
`ifdef TOPK_EVICT_OUT_EN
    , .evict_valid(evict_valid_d), .evict_data(evict_data_d)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Present one sample for one edge; returns at the following negedge.
  task automatic send_u(input logic [DW-1:0] v);
    @(negedge clk);
    din_u = v; din_valid_u = 1'b1;
    @(negedge clk);
    din_valid_u = 1'b0;
  endtask

  task automatic send_d(input logic [DW-1:0] v);
    @(negedge clk);
    din_d = v; din_valid_d = 1'b1;
    @(negedge clk);
    din_valid_d = 1'b0;
  endtask

  task automatic clear_both();
    @(negedge clk);
    clear_u = 1'b1; clear_d = 1'b1;
    @(negedge clk);
    clear_u = 1'b0; clear_d = 1'b0;
  endtask

  task automatic read_u(input string tag, input int idx, input logic [DW-1:0] exp_v, input logic exp_ok);
    rd_idx_u = IDX_W'(idx);
    #1;
    check({tag, "_dout"}, 32'(dout_u), 32'(exp_v));
    check({tag, "_valid"}, 32'(dout_valid_u), 32'(exp_ok));
  endtask

  task automatic read_d(input string tag, input int idx, input logic [DW-1:0] exp_v, input logic exp_ok);
    rd_idx_d = IDX_W'(idx);
    #1;
    check({tag, "_dout"}, 32'(dout_d), 32'(exp_v));
    check({tag, "_valid"}, 32'(dout_valid_d), 32'(exp_ok));
  endtask

  initial begin
    logic [DW-1:0] stream1 [4] = '{8'd5, 8'd9, 8'd3, 8'd7};
    logic [DW-1:0] exp1    [4] = '{8'd9, 8'd7, 8'd5, 8'd3};
    logic [DW-1:0] exp2    [4] = '{8'd9, 8'd8, 8'd7, 8'd5};

    reset = 1'b1;
    clear_u = 1'b0; din_valid_u = 1'b0; din_u = '0; rd_idx_u = '0;
    clear_d = 1'b0; din_valid_d = 1'b0; din_d = '0; rd_idx_d = '0;
    #1;
    check("rst_occ", 32'(occ_u), 0);
    check("rst_drop", 32'(drop_u), 0);
    read_u("rst_r0", 0, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill the table in unsorted order.
    for (int i = 0; i < 4; i++) begin
      send_u(stream1[i]);
      check($sformatf("t1_drop%0d", i), 32'(drop_u), 0);
    end
    check("t1_occ", 32'(occ_u), 4);
    for (int i = 0; i < 4; i++) read_u($sformatf("t1_r%0d", i), i, exp1[i], 1'b1);

    // Insert into a full table evicts the smallest.
    send_u(8'd8);
    check("t2_drop8", 32'(drop_u), 0);
    check("t2_occ", 32'(occ_u), 4);
`ifdef TOPK_EVICT_OUT_EN
    check("t2_ev_valid8", 32'(evict_valid_u), 1);
    check("t2_ev_data8", 32'(evict_data_u), 3);
`endif
    for (int i = 0; i < 4; i++) read_u($sformatf("t2_r%0d", i), i, exp2[i], 1'b1);
    send_u(8'd2);
    check("t2_drop2", 32'(drop_u), 1);
`ifdef TOPK_EVICT_OUT_EN
    check("t2_ev_valid2", 32'(evict_valid_u), 0);
    check("t2_ev_data2", 32'(evict_data_u), 3);
`endif
    read_u("t2_r3_after2", 3, 8'd5, 1'b1);
    @(negedge clk);
    check("t2_drop_idle", 32'(drop_u), 0);
    send_u(8'd7);
    check("t2_drop_dup7", 32'(drop_u), 1);
    read_u("t2_r2_dup7", 2, 8'd7, 1'b1);
    read_u("t2_r3_dup7", 3, 8'd5, 1'b1);

    // Duplicates: discarded when UNIQUE=1, stacked when UNIQUE=0.
    clear_both();
    send_u(8'd6);
    check("t3_drop_first6", 32'(drop_u), 0);
    send_u(8'd6);
    check("t3_drop_second6", 32'(drop_u), 1);
    check("t3_occ_u", 32'(occ_u), 1);
    send_d(8'd6); send_d(8'd6); send_d(8'd6);
    check("t3_occ_d", 32'(occ_d), 3);
    check("t3_drop_d", 32'(drop_d), 0);
    for (int i = 0; i < 3; i++) read_d($sformatf("t3_d_r%0d", i), i, 8'd6, 1'b1);
    read_d("t3_d_r3", 3, 8'd0, 1'b0);
    send_d(8'd7);
    read_d("t3_d_r0_7", 0, 8'd7, 1'b1);
    read_d("t3_d_r3_6", 3, 8'd6, 1'b1);

    // Empty slots accept zero; out-of-range reads.
    clear_both();
    send_u(8'd0);
    check("t4_occ_zero", 32'(occ_u), 1);
    read_u("t4_r0_zero", 0, 8'd0, 1'b1);
    send_u(8'd4);
    read_u("t4_r0", 0, 8'd4, 1'b1);
    read_u("t4_r1", 1, 8'd0, 1'b1);
    read_u("t4_r2", 2, 8'd0, 1'b0);
    read_u("t4_rK1", K + 1, 8'd0, 1'b0);

    // Clear wins over a simultaneous sample.
    @(negedge clk);
    clear_u = 1'b1; din_valid_u = 1'b1; din_u = 8'd200;
    @(negedge clk);
    clear_u = 1'b0; din_valid_u = 1'b0;
    check("t5_occ", 32'(occ_u), 0);
    check("t5_drop", 32'(drop_u), 0);
    read_u("t5_r0", 0, 8'd0, 1'b0);
    send_u(8'd200);
    read_u("t5_r0_200", 0, 8'd200, 1'b1);

    // Asynchronous reset between edges.
    send_u(8'd50);
    check("t6_occ_pre", 32'(occ_u), 2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_occ_async", 32'(occ_u), 0);
    read_u("t6_r0_async", 0, 8'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send_u(8'd255);
    send_u(8'd0);
    check("t6_occ", 32'(occ_u), 2);
    read_u("t6_r0", 0, 8'd255, 1'b1);
    read_u("t6_r1", 1, 8'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/topk_tracker.md
Name: topk_tracker

Overview:
Streaming running top-K tracker, the parametrised successor to the second-largest tracker. It keeps the K largest values seen since the last reset or clear as a descending-sorted register array. Any rank can be read through a select port, with a per-rank valid flag. Sits on sample streams (statistics/monitor paths) in place of fixed "largest/second-largest" logic.

Parameters:
DATA_WIDTH, 32, sample width in bits, unsigned compare
K, 4, number of tracked ranks, legal range 2..64
UNIQUE, 1, 1 = a value equal to any held value is discarded; 0 = duplicates occupy separate ranks
IDX_W, $clog2(K)+1, width of rd_idx; also wide enough to hold K

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear of all state, priority over din_valid
din_valid  input  1  din is a sample this cycle
din  input  DATA_WIDTH  sample value
rd_idx  input  IDX_W  rank to read; 0 = largest
dout  output  DATA_WIDTH  value at rank rd_idx
dout_valid  output  1  rank rd_idx is occupied
occ  output  IDX_W  occupied ranks, 0..K
drop  output  1  registered pulse: last accepted sample was discarded

Behaviour:
- State: slot[0..K-1], with slot[0] the largest; occ; drop.
- Invariant: slot[0..occ-1] are strictly descending when UNIQUE=1, non-increasing when UNIQUE=0. Slots at index >= occ hold 0.
- Reset (async, active-high): all slots 0, occ 0, drop 0. dout 0 and dout_valid 0 immediately.
- clear=1 at a clock edge: same state as reset, drop 0. Any din_valid that cycle is ignored.
- Insert (din_valid=1, clear=0), evaluated from pre-edge state:
  - p = count of occupied slots i (i < occ) with slot[i] > din, for UNIQUE=1.
  - p = count of occupied slots i with slot[i] >= din, for UNIQUE=0. New equal values go below existing equals.
  - UNIQUE=1 and din equals any occupied slot: discard, drop=1.
  - p == K (table full and din too small): discard, drop=1.
  - Otherwise: slot[j+1] <= slot[j] for p <= j <= K-2; slot[p] <= din; occ <= min(occ+1, K); drop=0.
  - When the table is full, the old slot[K-1] is evicted.
- Empty slots accept any value, including 0.
  - Example: first sample 0 gives occ=1, slot[0]=0. This differs from the zero-initialised compare scheme.
- din_valid=0 and clear=0: state held, drop <= 0.
- Latency: one cycle. A sample presented at edge n is visible on dout/occ after edge n. One sample per cycle at full throughput; no backpressure.
- Read path (combinational from registers):
  - rd_idx < occ: dout = slot[rd_idx], dout_valid = 1.
  - rd_idx >= occ, including rd_idx >= K: dout = 0, dout_valid = 0.
- Reset or clear mid-stream: the update in flight is lost; no partial shift is visible.
- Comparator array is K wide and fully parallel; no multi-cycle search.

Optional Feature:
Macro TOPK_EVICT_OUT_EN.
- Defined: adds outputs evict_valid (1) and evict_data (DATA_WIDTH), both registered.
  - evict_valid pulses one cycle when an insert into a full table pushes out the old slot[K-1].
  - evict_data holds that value.
  - On a discarded sample, evict_valid=0 and evict_data is held.
  - Reset/clear: both 0.
- Undefined: ports absent, no extra logic; core behaviour identical.

Test Plan:
1. K=4, UNIQUE=1, DATA_WIDTH=8. Stream 5,9,3,7 -> ranks 0..3 read 9,7,5,3; occ=4; drop never set.
2. Full table {9,7,5,3}, send 8 -> {9,8,7,5}. Send 2 -> unchanged, drop=1 next cycle. With TOPK_EVICT_OUT_EN: 8 gives evict_valid=1, evict_data=3; 2 gives evict_valid=0.
3. UNIQUE=1, send 6,6 -> occ=1, second sample drop=1. UNIQUE=0, send 6,6,6 -> occ=3, ranks 0..2 all read 6.
4. occ=2, rd_idx=2 -> dout=0, dout_valid=0. rd_idx=K+1 -> dout=0, dout_valid=0. First sample 0 -> rank0=0, dout_valid=1.
5. clear=1 together with din_valid=1 and din=200 -> occ=0, all ranks invalid. Next sample 200 -> rank0=200.
6. Async reset asserted mid-clock after inserts -> outputs 0 and occ 0 before the next edge. Release, stream max value 255 then 0 -> ranks read 255,0.
